// File: rtl/mem_access_stage.sv
// MEM stage: one data-memory request per load/store, stalling upstream until ack or
// abort after MAX_WAIT wait cycles; MEM/WB registers pass through, capture, or bubble.
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        zero_in,
  input  logic [31:0] b_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] aluoutput_in,
  input  logic [4:0]  rd_in,
  input  logic        branch_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] lmd_out,
  output logic [31:0] aluoutput_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        mem_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lmd;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_timeout;

  logic w_memop;
  logic w_in_idle;
  logic w_in_wait;
  logic w_ack;
  logic w_abort;
  logic w_stall;
  logic w_unused;

  assign w_memop   = mem_read_in | mem_write_in;
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_ack     = w_in_wait & dmem_ack;
  // Ack on the last allowed wait cycle still completes the access.
  assign w_abort   = w_in_wait & ~dmem_ack & (r_cnt == LP_CNT_LAST);
  assign w_stall   = (w_in_idle & w_memop) | (w_in_wait & ~dmem_ack & ~w_abort);
  assign w_unused  = ^npc_in;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_memop) w_state_nxt = S_WAIT;
      S_WAIT:  if (dmem_ack || w_abort) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_idle) r_cnt <= 8'd0;
      else           r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_lmd        <= 32'd0;
      r_alu        <= 32'd0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_in_idle && w_memop) begin
        r_req   <= 1'b1;
        r_we    <= mem_write_in & ~mem_read_in;
        r_addr  <= aluoutput_in;
        r_wdata <= b_in;
      end else if (w_ack || w_abort) begin
        r_req <= 1'b0;
      end

      if (w_abort) r_timeout <= 1'b1;

      // Stall and abort cycles both write a bubble; data fields hold.
      if (w_ack || (w_in_idle && !w_memop)) begin
        r_alu        <= aluoutput_in;
        r_rd         <= rd_in;
        r_reg_write  <= reg_write_in;
        r_mem_to_reg <= mem_to_reg_in;
        if (w_ack && !r_we) r_lmd <= dmem_rdata;
      end else begin
        r_reg_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end
    end
  end

  assign stall          = w_stall;
  assign pc_src         = branch_in & zero_in & ~w_stall;
  assign branch_target  = aluoutput_in;
  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign lmd_out        = r_lmd;
  assign aluoutput_out  = r_alu;
  assign rd_out         = r_rd;
  assign reg_write_out  = r_reg_write;
  assign mem_to_reg_out = r_mem_to_reg;
  assign mem_timeout    = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (MAX_WAIT=4): directed stimulus feeding expected
// memory requests and write-backs into queues checked by independent monitors.
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] lmd;
    logic        mtr;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        zero_in = 1'b0;
  logic [31:0] b_in = '0;
  logic [31:0] npc_in = '0;
  logic [31:0] aluoutput_in = '0;
  logic [4:0]  rd_in = '0;
  logic        branch_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall, pc_src, dmem_req, dmem_we;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, lmd_out, aluoutput_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_to_reg_out, mem_timeout;

  int n_checks = 0;
  int n_errors = 0;
  req_t req_q[$];
  wb_t  wb_q[$];
  logic [31:0] m_lmd = '0;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .zero_in(zero_in), .b_in(b_in), .npc_in(npc_in),
    .aluoutput_in(aluoutput_in), .rd_in(rd_in), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .lmd_out(lmd_out), .aluoutput_out(aluoutput_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request monitor: a rising dmem_req pops the next expected request, which must
  // then stay unchanged on the bus until dmem_req drops.
  req_t cur_req;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      if (prev_req !== 1'b1) begin
        if (req_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: addr %h with no request expected", dmem_addr);
          cur_req = '{addr: dmem_addr, we: dmem_we, wdata: dmem_wdata};
        end else begin
          cur_req = req_q.pop_front();
        end
      end
      chk("req_addr", dmem_addr, cur_req.addr);
      chk("req_we", dmem_we, cur_req.we);
      chk("req_wdata", dmem_wdata, cur_req.wdata);
    end
    prev_req = dmem_req;
  end

  // Write-back monitor: every cycle with reg_write_out set must match the next expectation.
  always @(negedge clk) begin
    wb_t e;
    if (reg_write_out === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_wb: alu %h rd %0d with no write-back expected", aluoutput_out, rd_out);
      end else begin
        e = wb_q.pop_front();
        chk("wb_alu", aluoutput_out, e.alu);
        chk("wb_rd", 32'(rd_out), 32'(e.rd));
        chk("wb_lmd", lmd_out, e.lmd);
        chk("wb_mtr", mem_to_reg_out, e.mtr);
      end
    end
  end

  task automatic set_nop();
    aluoutput_in = '0; b_in = '0; rd_in = '0; branch_in = 0; zero_in = 0;
    mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd);
    aluoutput_in = alu; rd_in = rd; reg_write_in = 1;
    wb_q.push_back('{alu: alu, rd: rd, lmd: m_lmd, mtr: 1'b0});
    @(negedge clk); chk("alu_stall", stall, 0);
    next_cycle();
    set_nop();
  endtask

  task automatic do_mem(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input logic rdv, input logic wrv, input logic rw,
                        input logic mtr, input int nwait, input bit ack);
    req_t r;
    aluoutput_in = addr; b_in = wdata; rd_in = rd; mem_read_in = rdv;
    mem_write_in = wrv; reg_write_in = rw; mem_to_reg_in = mtr;
    branch_in = 1; zero_in = 1;
    r = '{addr: addr, we: wrv & ~rdv, wdata: wdata};
    req_q.push_back(r);
    @(negedge clk);
    chk("issue_stall", stall, 1);
    chk("stall_pc_src", pc_src, 0);
    for (int k = 0; k < nwait; k++) begin
      next_cycle();
      @(negedge clk); chk("wait_stall", stall, 1);
    end
    next_cycle();
    if (ack) begin
      dmem_ack = 1; dmem_rdata = rdata;
      if (!r.we) m_lmd = rdata;
      if (rw) wb_q.push_back('{alu: addr, rd: rd, lmd: m_lmd, mtr: mtr});
      @(negedge clk); chk("ack_stall", stall, 0);
      next_cycle();
      dmem_ack = 0;
      chk("ack_req_drop", dmem_req, 0);
    end else begin
      @(negedge clk); chk("abort_stall", stall, 0);
      next_cycle();
      chk("abort_req_drop", dmem_req, 0);
      chk("abort_timeout", mem_timeout, 1);
      chk("abort_bubble", reg_write_out, 0);
    end
    set_nop();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_lmd", lmd_out, 0);
    chk("rst_rw", reg_write_out, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall", stall, 0);
    next_cycle();

    alu_op(32'h10, 5'd3);
    alu_op(32'h20, 5'd7);
    alu_op(32'h30, 5'd9);

    branch_in = 1; zero_in = 1; aluoutput_in = 32'h40;
    @(negedge clk);
    chk("br_taken", pc_src, 1);
    chk("br_target", branch_target, 32'h40);
    next_cycle();
    zero_in = 0;
    @(negedge clk);
    chk("br_not_taken", pc_src, 0);
    next_cycle();
    set_nop();

    // Load, zero wait states.
    do_mem(32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1, 0, 1, 1, 0, 1);
    // Store, 3 wait states; ack lands on the abort cycle and must win.
    do_mem(32'h200, 32'hA5A5A5A5, 32'hFFFF0000, 5'd6, 0, 1, 1, 0, 3, 1);
    chk("ack_beats_abort", mem_timeout, 0);
    // Read and write both set behaves as a read.
    do_mem(32'h300, 32'h77777777, 32'h12345678, 5'd8, 1, 1, 1, 1, 1, 1);
    alu_op(32'h44, 5'd4);
    // Timeout with no ack.
    do_mem(32'h400, 32'h0, 32'h0, 5'd11, 1, 0, 1, 1, 3, 0);
    alu_op(32'h55, 5'd10);
    @(negedge clk); chk("timeout_sticky", mem_timeout, 1);
    next_cycle();

    // Reset during a pending read; the late ack must be ignored.
    aluoutput_in = 32'h500; rd_in = 5'd12; mem_read_in = 1; reg_write_in = 1; mem_to_reg_in = 1;
    req_q.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
    next_cycle();
    next_cycle();
    reset = 1; set_nop();
    next_cycle();
    reset = 0; dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0; m_lmd = '0;
    @(negedge clk);
    chk("midrst_req", dmem_req, 0);
    chk("midrst_lmd", lmd_out, 0);
    chk("midrst_alu", aluoutput_out, 0);
    chk("midrst_rd", 32'(rd_out), 0);
    chk("midrst_timeout", mem_timeout, 0);
    next_cycle();
    @(negedge clk);
    chk("late_ack_rw", reg_write_out, 0);
    chk("late_ack_lmd", lmd_out, 0);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", stall, 0);
    dmem_ack = 0;
    repeat (3) next_cycle();

    chk("req_q_drained", req_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum WAIT cycles without dmem_ack before abort (range 1..255).
REQ-002 SHALL have port clk  in  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have EX/MEM-side inputs: zero_in 1, b_in 32 (store data), npc_in 32, aluoutput_in 32 (address/ALU result), rd_in 5, branch_in 1, mem_read_in 1, mem_write_in 1, reg_write_in 1, mem_to_reg_in 1.
REQ-005 SHALL have port stall  out  1  holds all upstream pipeline registers when high.
REQ-006 SHALL have ports pc_src  out  1 (take branch) and branch_target  out  32 (branch address to fetch).
REQ-007 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_ack in 1, dmem_rdata in 32.
REQ-008 SHALL have MEM/WB outputs, all registered: lmd_out 32, aluoutput_out 32, rd_out 5, reg_write_out 1, mem_to_reg_out 1.
REQ-009 SHALL have port mem_timeout  out  1  sticky abort flag.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and WAIT; memop = mem_read_in | mem_write_in.
REQ-011 In IDLE with memop, SHALL register dmem_req=1, dmem_addr=aluoutput_in, dmem_wdata=b_in, dmem_we=mem_write_in & ~mem_read_in, and go to WAIT.
REQ-012 When mem_read_in and mem_write_in are both high, SHALL treat the operation as a read (dmem_we=0).
REQ-013 In WAIT, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold stable until the ack or abort edge.
REQ-014 In WAIT with dmem_ack=1, on that edge SHALL: drop dmem_req, go to IDLE, set lmd_out=dmem_rdata (reads) or hold lmd_out (writes), and load aluoutput_out, rd_out, reg_write_out and mem_to_reg_out from the inputs.
REQ-015 The stall equation SHALL be stall = (IDLE & memop) | (WAIT & ~dmem_ack & ~abort), evaluated combinationally.
REQ-016 Minimum memory-op latency SHALL be 2 cycles (issue cycle plus ack cycle); each wait state SHALL add 1.
REQ-017 In IDLE without memop, SHALL load the MEM/WB registers from the inputs every cycle (1-cycle pass-through), with lmd_out held.
REQ-018 While stall=1, SHALL load a bubble on each edge: reg_write_out=0, mem_to_reg_out=0; lmd_out, aluoutput_out and rd_out SHALL hold.
REQ-019 SHALL count WAIT cycles with an 8-bit counter, cleared on entry to WAIT.
REQ-020 abort SHALL be asserted when the counter equals MAX_WAIT-1 and dmem_ack=0.
REQ-021 On abort, SHALL: set mem_timeout=1, drop dmem_req, go to IDLE, and load a bubble into MEM/WB; stall SHALL be 0 in that cycle.
REQ-022 If dmem_ack and the abort condition coincide, ack SHALL win; mem_timeout stays unchanged.
REQ-023 dmem_ack in IDLE SHALL be ignored.
REQ-024 mem_timeout SHALL clear only on reset.
REQ-025 pc_src SHALL equal branch_in & zero_in & ~stall, combinationally.
REQ-026 branch_target SHALL equal aluoutput_in.

Reset
REQ-027 On reset at a rising edge, SHALL enter IDLE and clear the counter.
REQ-028 On reset, SHALL set dmem_req, dmem_we, dmem_addr, dmem_wdata, lmd_out, aluoutput_out, rd_out, reg_write_out, mem_to_reg_out and mem_timeout to 0.
REQ-029 Reset asserted in WAIT SHALL abandon the access without a write-back; dmem_req SHALL be 0 from the next cycle.

Verification
REQ-030 ALU op: aluoutput_in=0x10, rd_in=3, reg_write_in=1, no memop -> next edge aluoutput_out=0x10, rd_out=3, reg_write_out=1, stall=0 throughout.
REQ-031 Load, zero wait: mem_read_in=1, aluoutput_in=0x100, ack on the first WAIT cycle with rdata=0xDEADBEEF -> stall high for 1 cycle, dmem_addr=0x100, lmd_out=0xDEADBEEF, reg_write_out=1 after 2 edges.
REQ-032 Store, 3 wait states: mem_write_in=1, b_in=0xA5A5A5A5 -> dmem_we=1, dmem_wdata stable for 4 WAIT cycles, stall high for 4 cycles, bubble written back during the stall.
REQ-033 Timeout: MAX_WAIT=4, read with no ack -> dmem_req drops after 4 WAIT cycles, mem_timeout=1 sticky, reg_write_out=0, next instruction proceeds.
REQ-034 Branch: branch_in=1, zero_in=1, aluoutput_in=0x40 -> pc_src=1, branch_target=0x40; with zero_in=0 -> pc_src=0.
REQ-035 Reset mid-WAIT: reset for 1 cycle during a pending read -> IDLE, dmem_req=0, all outputs 0; a late ack afterwards is ignored.
